halut_encoder_n: RTL

HALUT_ENCODER_N -- requirements
Module: halut_encoder_n

---
 rtl/halut_pkg.sv | 29 ++
 rtl/halut_encoder.sv | 102 ++++++++++
 rtl/halut_encoder_n.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/halut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : halut_pkg
// Description : Shared types and default dimensions for the HALUT encoder
//               slice: codebook/prototype defaults, the encoder FSM state
//               enum and the {c_addr, k_addr} result FIFO entry.
// Revision    : 1.0 - initial release
// ============================================================================
package halut_pkg;

    localparam int K             = 16;  // prototypes per codebook
    localparam int C             = 32;  // codebook count
    localparam int DataTypeWidth = 16;  // input / threshold width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2
    } enc_state_e;

    // Field widths follow the package dimensions; a design instantiated with
    // larger K or C than these must widen the package values as well.
    typedef struct packed {
        logic [$clog2(C)-1:0] c_addr;
        logic [$clog2(K)-1:0] k_addr;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/halut_encoder.sv
`default_nettype none
// ============================================================================
// Module      : halut_encoder
// Description : One time-multiplexed decision-tree encoder unit. The unit owns
//               codebooks EncUnitNumber + EncUnits*j and spends EncUnits
//               cycles per codebook; in the last cycle of each slot it walks
//               the balanced tree (signed a_input > threshold -> right child)
//               and registers {c, k} with a one-cycle valid pulse.
//               Disabling the unit restarts it at phase 0 / codebook slot 0.
// Ports       : clk_i, rst_i      - clock, synchronous active-high reset
//               enable_i          - unit enable (ramp mask bit)
//               a_input_i         - one signed input per tree level
//               waddr_i/wdata_i/we_i - threshold memory write port
//               c_addr_o/k_addr_o/valid_o - registered result
// Revision    : 1.0 - initial release
// ============================================================================
module halut_encoder
    import halut_pkg::*;
#(
    parameter int K             = halut_pkg::K,
    parameter int C             = halut_pkg::C,
    parameter int DataTypeWidth = halut_pkg::DataTypeWidth,
    parameter int EncUnits      = 4,
    parameter int EncUnitNumber = 0,
    localparam int CAddrWidth         = $clog2(C),
    localparam int TreeDepth          = $clog2(K),
    localparam int ThreshMemAddrWidth = $clog2((C / EncUnits) * K)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            enable_i,
    input  logic signed [DataTypeWidth-1:0] a_input_i [TreeDepth],
    input  logic [ThreshMemAddrWidth-1:0]   waddr_i,
    input  logic [DataTypeWidth-1:0]        wdata_i,
    input  logic                            we_i,
    output logic [CAddrWidth-1:0]           c_addr_o,
    output logic [TreeDepth-1:0]            k_addr_o,
    output logic                            valid_o
);

    localparam int CB_PER_UNIT = C / EncUnits;
    localparam int CB_W        = (CB_PER_UNIT > 1) ? $clog2(CB_PER_UNIT) : 1;
    localparam int PH_W        = $clog2(EncUnits);

    logic signed [DataTypeWidth-1:0] r_thresh [CB_PER_UNIT*K];
    logic [PH_W-1:0]       r_phase;
    logic [CB_W-1:0]       r_cb;
    logic [CAddrWidth-1:0] r_c;
    logic [TreeDepth-1:0]  r_k;
    logic                  r_valid;
    logic [TreeDepth-1:0]  w_k;

    // Threshold storage is configuration data and carries no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_thresh[waddr_i] <= wdata_i;
        end
    end

    // Heap-ordered tree per codebook slot: node n has children 2n+1 / 2n+2,
    // slot j occupies thresholds [j*K, j*K+K-2]. Level 0 decides the MSB of k.
    always_comb begin
        logic [TreeDepth:0]            w_node;
        logic [ThreshMemAddrWidth-1:0] w_addr;
        logic                          w_bit;
        w_node = '0;
        w_addr = '0;
        w_bit  = 1'b0;
        w_k    = '0;
        for (int l = 0; l < TreeDepth; l++) begin
            w_addr = ThreshMemAddrWidth'(int'(r_cb) * K + int'(w_node));
            w_bit  = (a_input_i[l] > r_thresh[w_addr]);
            w_k    = (w_k << 1) | TreeDepth'(w_bit);
            w_node = (w_node << 1) + (TreeDepth+1)'(1) + (TreeDepth+1)'(w_bit);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            r_phase <= '0;
            r_cb    <= '0;
            r_c     <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_phase <= r_phase + PH_W'(1);  // EncUnits is a power of two
            if (r_phase == PH_W'(EncUnits - 1)) begin
                r_valid <= 1'b1;
                r_k     <= w_k;
                r_c     <= CAddrWidth'(EncUnitNumber + EncUnits * int'(r_cb));
                r_cb    <= (r_cb == CB_W'(CB_PER_UNIT - 1)) ? '0 : r_cb + CB_W'(1);
            end
        end
    end

    assign c_addr_o = r_c;
    assign k_addr_o = r_k;
    assign valid_o  = r_valid;

endmodule
`default_nettype wire

// File: rtl/halut_encoder_n.sv
`default_nettype none
// ============================================================================
// Module      : halut_encoder_n
// Description : EncUnits halut_encoder units behind a round-robin collector
//               and an inline result FIFO. FSM IDLE -> RAMP (enable mask
//               fills one bit per cycle so units start staggered) -> RUN
//               (unit sel sampled each cycle, valid results pushed).
//               Optional macro HALUT_ENC_PERF_CNT_EN adds result_count_o.
// Ports       : clk_i, rst_i      - clock, synchronous active-high reset
//               a_input_i         - per-unit tree inputs
//               waddr_i/wdata_i/we_i - per-unit threshold write ports
//               encoder_i         - run request (low returns to IDLE)
//               c_addr_o/k_addr_o/valid_o/ready_i - FIFO head handshake
//               fifo_level_o      - occupied FIFO entries
//               overflow_o        - sticky result-dropped flag
//               result_count_o    - accepted pushes (macro builds only)
// Revision    : 1.0 - initial release
// ============================================================================
module halut_encoder_n
    import halut_pkg::*;
#(
    parameter int K             = halut_pkg::K,
    parameter int C             = halut_pkg::C,
    parameter int DataTypeWidth = halut_pkg::DataTypeWidth,
    parameter int EncUnits      = 4,
    parameter int FifoDepth     = 4,
    localparam int CAddrWidth         = $clog2(C),
    localparam int TreeDepth          = $clog2(K),
    localparam int ThreshMemAddrWidth = $clog2((C / EncUnits) * K),
    localparam int LvlWidth           = $clog2(FifoDepth + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic signed [DataTypeWidth-1:0] a_input_i [EncUnits][TreeDepth],
    input  logic [ThreshMemAddrWidth-1:0]   waddr_i [EncUnits],
    input  logic [DataTypeWidth-1:0]        wdata_i [EncUnits],
    input  logic [EncUnits-1:0]             we_i,
    input  logic                            encoder_i,
    output logic [CAddrWidth-1:0]           c_addr_o,
    output logic [TreeDepth-1:0]            k_addr_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [LvlWidth-1:0]             fifo_level_o,
`ifdef HALUT_ENC_PERF_CNT_EN
    output logic [31:0]                     result_count_o,
`endif
    output logic                            overflow_o
);

    localparam int SEL_W  = $clog2(EncUnits);
    localparam int PTR_W  = $clog2(FifoDepth);
    localparam int PKG_CW = $clog2(halut_pkg::C);
    localparam int PKG_KW = $clog2(halut_pkg::K);

    enc_state_e            r_state, w_state_nxt;
    logic [EncUnits-1:0]   r_mask, w_mask_nxt;
    logic [SEL_W-1:0]      r_sel, w_sel_nxt;
    logic                  w_run_start;

    logic [CAddrWidth-1:0] w_unit_c [EncUnits];
    logic [TreeDepth-1:0]  w_unit_k [EncUnits];
    logic [EncUnits-1:0]   w_unit_valid;

    fifo_entry_t           r_fifo [FifoDepth];
    logic [PTR_W-1:0]      r_wptr, r_rptr;
    logic [LvlWidth-1:0]   r_level;
    logic                  r_overflow;
    fifo_entry_t           w_entry, w_head;
    logic                  w_push, w_pop, w_accept, w_drop, w_empty, w_full;

    for (genvar x = 0; x < EncUnits; x++) begin : g_unit
        halut_encoder #(
            .K             (K),
            .C             (C),
            .DataTypeWidth (DataTypeWidth),
            .EncUnits      (EncUnits),
            .EncUnitNumber (x)
        ) u_enc (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .enable_i  (r_mask[x]),
            .a_input_i (a_input_i[x]),
            .waddr_i   (waddr_i[x]),
            .wdata_i   (wdata_i[x]),
            .we_i      (we_i[x]),
            .c_addr_o  (w_unit_c[x]),
            .k_addr_o  (w_unit_k[x]),
            .valid_o   (w_unit_valid[x])
        );
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_sel_nxt   = r_sel;
        w_run_start = 1'b0;
        if (!encoder_i) begin
            w_state_nxt = ST_IDLE;
            w_mask_nxt  = '0;
            w_sel_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Unit 0 is enabled on the first RAMP cycle so that unit x
                    // starts exactly EncUnits cycles before RUN samples it.
                    w_state_nxt = ST_RAMP;
                    w_mask_nxt  = EncUnits'(1);
                    w_run_start = 1'b1;
                end
                ST_RAMP: begin
                    w_mask_nxt = (r_mask << 1) | EncUnits'(1);
                    if (&r_mask) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_sel_nxt = r_sel + SEL_W'(1);  // power-of-two wrap
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_mask_nxt  = '0;
                    w_sel_nxt   = '0;
                end
            endcase
        end
    end

    // --------------------------------------------------------------- FIFO
    assign w_push   = (r_state == ST_RUN) && w_unit_valid[r_sel];
    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LvlWidth'(FifoDepth));
    assign w_pop    = !w_empty && ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    always_comb begin
        w_entry        = '0;
        w_entry.c_addr = PKG_CW'(w_unit_c[r_sel]);
        w_entry.k_addr = PKG_KW'(w_unit_k[r_sel]);
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_fifo[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LvlWidth'(1);
                2'b01:   r_level <= r_level - LvlWidth'(1);
                default: r_level <= r_level;
            endcase
            if (w_run_start) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head       = r_fifo[r_rptr];
    assign valid_o      = !w_empty;
    assign c_addr_o     = w_empty ? '0 : CAddrWidth'(w_head.c_addr);
    assign k_addr_o     = w_empty ? '0 : TreeDepth'(w_head.k_addr);
    assign fifo_level_o = r_level;
    assign overflow_o   = r_overflow;

`ifdef HALUT_ENC_PERF_CNT_EN
    logic [31:0] r_result_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result_count <= '0;
        end else if (w_accept) begin
            r_result_count <= r_result_count + 32'd1;
        end
    end

    assign result_count_o = r_result_count;
`endif

endmodule
`default_nettype wire
